// File: rtl/xbar_bp_rr_pkg.sv
// Shared types and defaults for the PE-to-accumulate-buffer crossbar.
// DATA_PACKET is the PE packet format; dst_of maps a packet index to its bank.
package xbar_bp_rr_pkg;

    localparam int unsigned NUM_SRC_DEF    = 8;
    localparam int unsigned NUM_DST_DEF    = 8;
    localparam int unsigned FIFO_DEPTH_DEF = 4;
    localparam int unsigned WR_PORTS_DEF   = 2;

    localparam int unsigned IDX_W = 8;
    localparam int unsigned PAY_W = 16;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] index;
        logic [PAY_W-1:0] payload;
    } DATA_PACKET;

    // num_dst is a power of two, so the modulo reduces to a mask
    function automatic int unsigned dst_of(input logic [IDX_W-1:0] index,
                                           input int unsigned num_dst);
        return 32'(index) & (num_dst - 1);
    endfunction

endpackage

// File: rtl/xbar_bp_rr_if.sv
// Packet, backpressure and status bundle between the PE array and the bank crossbar.
interface xbar_bp_rr_if
    import xbar_bp_rr_pkg::*;
#(
    parameter int unsigned NUM_SRC    = NUM_SRC_DEF,
    parameter int unsigned NUM_DST    = NUM_DST_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) ();

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    DATA_PACKET [NUM_SRC-1:0]            in_packet;
    logic       [NUM_SRC-1:0]            in_ready;
    DATA_PACKET [NUM_DST-1:0]            out_packet;
    logic       [NUM_DST-1:0]            out_valid;
    logic       [NUM_DST-1:0]            out_ready;
    logic       [NUM_DST-1:0][CNT_W-1:0] fifo_count;
    logic                                busy;
    logic                                drained;

    modport master (
        output in_packet, out_ready,
        input  in_ready, out_packet, out_valid, fifo_count, busy, drained
    );

    modport slave (
        input  in_packet, out_ready,
        output in_ready, out_packet, out_valid, fifo_count, busy, drained
    );

endinterface

// File: rtl/xbar_bp_rr_picker.sv
// Round-robin picker for one bank: grants up to i_slots requesters starting at i_start,
// reporting each grant's write-slot offset, the grant count and the next scan start.
module xbar_bp_rr_picker #(
    parameter  int unsigned NUM_SRC  = 8,
    parameter  int unsigned WR_PORTS = 2,
    localparam int unsigned SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1,
    localparam int unsigned GNT_W    = $clog2(WR_PORTS + 1)
) (
    input  logic [NUM_SRC-1:0]            i_req,
    input  logic [SRC_W-1:0]              i_start,
    input  logic [GNT_W-1:0]              i_slots,
    output logic [NUM_SRC-1:0]            o_grant,
    output logic [NUM_SRC-1:0][GNT_W-1:0] o_offset,
    output logic [GNT_W-1:0]              o_count,
    output logic [SRC_W-1:0]              o_next
);

    logic [SRC_W:0]   w_sum;
    logic [SRC_W-1:0] w_idx;

    always_comb begin
        o_grant  = '0;
        o_offset = '0;
        o_count  = '0;
        o_next   = i_start;
        w_sum    = '0;
        w_idx    = '0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            w_sum = {1'b0, i_start} + (SRC_W+1)'(k);
            w_idx = (w_sum >= (SRC_W+1)'(NUM_SRC)) ? SRC_W'(w_sum - (SRC_W+1)'(NUM_SRC))
                                                   : SRC_W'(w_sum);
            if (i_req[w_idx] && (o_count < i_slots)) begin
                o_grant[w_idx]  = 1'b1;
                o_offset[w_idx] = o_count;
                o_count         = o_count + GNT_W'(1);
                o_next          = (32'(w_idx) + 1 == NUM_SRC) ? '0 : w_idx + SRC_W'(1);
            end
        end
    end

endmodule

// File: rtl/xbar_bp_rr.sv
// Crossbar from PE sources to accumulate-buffer banks: per-bank FIFO, round-robin
// admission capped at WR_PORTS pushes per cycle, exact occupancy counters.
module xbar_bp_rr
    import xbar_bp_rr_pkg::*;
#(
    parameter int unsigned NUM_SRC    = NUM_SRC_DEF,
    parameter int unsigned NUM_DST    = NUM_DST_DEF,
    parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int unsigned WR_PORTS   = WR_PORTS_DEF
) (
    input  logic         clock,
    input  logic         reset_n,
    xbar_bp_rr_if.slave  bus
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned SRC_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int unsigned GNT_W = $clog2(WR_PORTS + 1);

    logic [NUM_DST-1:0][NUM_SRC-1:0]            w_req;
    logic [NUM_DST-1:0][NUM_SRC-1:0]            w_grant;
    logic [NUM_DST-1:0][NUM_SRC-1:0][GNT_W-1:0] w_offset;
    logic [NUM_DST-1:0]                         w_busy;
    logic [NUM_DST-1:0]                         w_empty;

    always_comb begin
        w_req = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            for (int unsigned d = 0; d < NUM_DST; d++) begin
                w_req[d][i] = bus.in_packet[i].valid &&
                              (dst_of(bus.in_packet[i].index, NUM_DST) == d);
            end
        end
    end

    for (genvar gd = 0; gd < NUM_DST; gd++) begin : g_bank
        logic [CNT_W-1:0] r_count;
        logic [PTR_W-1:0] r_wr_ptr;
        logic [PTR_W-1:0] r_rd_ptr;
        logic [SRC_W-1:0] r_rr_ptr;
        DATA_PACKET       r_mem [FIFO_DEPTH];
        logic [GNT_W-1:0] w_slots;
        logic [GNT_W-1:0] w_gcount;
        logic [SRC_W-1:0] w_next;
        logic             w_pop;

        // Slots come from the registered count only; a same-cycle pop never frees one
        assign w_slots = (32'(r_count) + WR_PORTS > FIFO_DEPTH)
                       ? GNT_W'(FIFO_DEPTH - 32'(r_count))
                       : GNT_W'(WR_PORTS);
        assign w_pop   = (r_count != '0) && bus.out_ready[gd];

        xbar_bp_rr_picker #(
            .NUM_SRC  (NUM_SRC),
            .WR_PORTS (WR_PORTS)
        ) u_picker (
            .i_req    (w_req[gd]),
            .i_start  (r_rr_ptr),
            .i_slots  (w_slots),
            .o_grant  (w_grant[gd]),
            .o_offset (w_offset[gd]),
            .o_count  (w_gcount),
            .o_next   (w_next)
        );

        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_rr_ptr <= '0;
            end else begin
                r_count  <= r_count + CNT_W'(w_gcount) - CNT_W'(w_pop);
                r_wr_ptr <= r_wr_ptr + PTR_W'(w_gcount);
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                if (w_gcount != '0) begin
                    r_rr_ptr <= w_next;
                end
            end
        end

        always_ff @(posedge clock) begin
            for (int unsigned i = 0; i < NUM_SRC; i++) begin
                if (w_grant[gd][i]) begin
                    r_mem[r_wr_ptr + PTR_W'(w_offset[gd][i])] <= bus.in_packet[i];
                end
            end
        end

        assign bus.out_valid[gd]  = (r_count != '0);
        assign bus.out_packet[gd] = r_mem[r_rd_ptr];
        assign bus.fifo_count[gd] = r_count;
        assign w_busy[gd]         = (r_count > CNT_W'(1));
        assign w_empty[gd]        = (r_count == '0);
    end

    always_comb begin
        bus.in_ready = '0;
        for (int unsigned d = 0; d < NUM_DST; d++) begin
            bus.in_ready = bus.in_ready | w_grant[d];
        end
    end

    assign bus.busy    = |w_busy;
    assign bus.drained = &w_empty;

endmodule
